// File: rtl/ifu_fetch.sv
// ifu_fetch: sequential-PC instruction fetch with credit-limited memory requests,
// in-order response tracking, redirect flush and a registered buffer toward decode.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          CNT_W      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        valid_next,
    input  logic        ready_next
);
    localparam int              AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] fifo_count;
    logic [AW-1:0]    fifo_rd;
    logic [AW-1:0]    fifo_wr;
    logic [AW-1:0]    pcq_rd;
    logic [AW-1:0]    pcq_wr;

    logic [31:0] fifo_pc   [FIFO_DEPTH];
    logic [31:0] fifo_inst [FIFO_DEPTH];
    logic [31:0] pcq       [FIFO_DEPTH];

    logic [CNT_W:0] in_use;
    logic           fifo_empty;
    logic           req_fire;
    logic           rsp_fire;
    logic           push;
    logic           pop;
    logic           unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credit counts dropped in-flight fetches too, so the buffer can never overflow.
    assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
    assign fifo_empty     = (fifo_count == '0);
    assign imem_req_valid = ~rst & ~redirect_valid & (in_use < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_fire       = imem_rsp_valid & (outstanding != '0);
    assign push           = rsp_fire & (drop == '0) & ~redirect_valid;
    assign valid_next     = ~fifo_empty & ~redirect_valid;
    assign pop            = valid_next & ready_next;
    assign inst           = fifo_empty ? 32'h0 : fifo_inst[fifo_rd];
    assign pc             = fifo_empty ? 32'h0 : fifo_pc[fifo_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fifo_count  <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (req_fire) pcq_wr <= pcq_wr + AW'(1);
            if (rsp_fire) pcq_rd <= pcq_rd + AW'(1);
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);

            // Every request still in flight at a redirect belongs to the wrong path.
            if (redirect_valid) begin
                drop <= outstanding - CNT_W'(rsp_fire);
            end else if (rsp_fire && drop != '0) begin
                drop <= drop - CNT_W'(1);
            end

            if (redirect_valid) begin
                fifo_count <= '0;
                fifo_rd    <= '0;
                fifo_wr    <= '0;
            end else begin
                if (push) fifo_wr <= fifo_wr + AW'(1);
                if (pop)  fifo_rd <= fifo_rd + AW'(1);
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // NOTE: storage arrays carry no reset; the counters and pointers alone decide validity.
    always_ff @(posedge clk) begin
        if (req_fire) pcq[pcq_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[fifo_wr]   <= pcq[pcq_rd];
            fifo_inst[fifo_wr] <= imem_rsp_data;
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && outstanding == '0));

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: queue-based reference model of fetch, memory and decode,
// compared every cycle, plus scenario-specific checks.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid_next;
    logic        ready_next = 1'b0;

    ifu_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst(inst), .pc(pc),
        .valid_next(valid_next), .ready_next(ready_next)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic dead; int due; } flight_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } pair_t;

    // Model: in-flight fetches double as the memory's pending queue.
    flight_t     m_flight[$];
    pair_t       m_fifo[$];
    logic [31:0] m_fetch_pc = RESET_PC;

    pair_t       delivered[$];
    logic [31:0] req_log[$];

    int cycle = 0;
    int checks = 0;
    int errors = 0;
    int mem_ready_mode = 1;   // 0 never ready, 1 always, 2 random
    int lat_min = 1;
    int lat_max = 1;

    logic        s_req_valid, s_valid_next, s_req_fire;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        logic        rsp, req_exp, vn_exp, req_fire, pop;
        logic [31:0] pc_exp, inst_exp;
        flight_t     f;
        case (mem_ready_mode)
            0:       imem_req_ready = 1'b0;
            1:       imem_req_ready = 1'b1;
            default: imem_req_ready = 1'($urandom_range(1));
        endcase
        rsp = !rst && m_flight.size() > 0 && m_flight[0].due <= cycle;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? data_of(m_flight[0].pc) : $urandom;

        req_exp  = !rst && !redirect_valid && (m_flight.size() + m_fifo.size() < DEPTH);
        vn_exp   = m_fifo.size() > 0 && !redirect_valid;
        pc_exp   = m_fifo.size() > 0 ? m_fifo[0].pc : 32'h0;
        inst_exp = m_fifo.size() > 0 ? m_fifo[0].inst : 32'h0;

        @(negedge clk);
        s_req_valid = imem_req_valid; s_addr = imem_req_addr;
        s_valid_next = valid_next; s_pc = pc; s_inst = inst;
        s_req_fire = imem_req_valid && imem_req_ready;

        checks++;
        if (imem_req_valid !== req_exp) begin
            errors++; $display("FAIL req_valid cycle %0d: got %b expected %b", cycle, imem_req_valid, req_exp);
        end
        checks++;
        if (imem_req_addr !== m_fetch_pc) begin
            errors++; $display("FAIL req_addr cycle %0d: got %h expected %h", cycle, imem_req_addr, m_fetch_pc);
        end
        checks++;
        if (valid_next !== vn_exp) begin
            errors++; $display("FAIL valid_next cycle %0d: got %b expected %b", cycle, valid_next, vn_exp);
        end
        checks++;
        if (pc !== pc_exp || inst !== inst_exp) begin
            errors++; $display("FAIL head_pair cycle %0d: got %h/%h expected %h/%h", cycle, pc, inst, pc_exp, inst_exp);
        end

        if (s_req_fire) req_log.push_back(imem_req_addr);
        if (valid_next && ready_next) delivered.push_back({pc, inst});

        req_fire = req_exp && imem_req_ready;
        pop      = vn_exp && ready_next;
        if (rst) begin
            m_fetch_pc = RESET_PC;
            m_flight.delete();
            m_fifo.delete();
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (rsp) begin
                f = m_flight.pop_front();
                if (!f.dead && !redirect_valid) m_fifo.push_back({f.pc, data_of(f.pc)});
            end
            if (redirect_valid) begin
                m_fifo.delete();
                for (int i = 0; i < m_flight.size(); i++) m_flight[i].dead = 1'b1;
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
            end else if (req_fire) begin
                m_flight.push_back({m_fetch_pc, 1'b0, cycle + int'($urandom_range(lat_max, lat_min))});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; ready_next = 1'b0;
        mem_ready_mode = 1; lat_min = 1; lat_max = 1;
        tick();
        rst = 1'b0;
        delivered.delete();
        req_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (s_req_valid !== 1'b0 || s_valid_next !== 1'b0 || s_pc !== 32'h0 || s_inst !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: got req=%b vn=%b pc=%h inst=%h expected 0/0/0/0",
                               s_req_valid, s_valid_next, s_pc, s_inst);
        end
        checks++;
        if (s_addr !== RESET_PC) begin
            errors++; $display("FAIL reset_addr: got %h expected %h", s_addr, RESET_PC);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int first_req = -1, first_vn = -1, c;
        do_reset();
        ready_next = 1'b1;
        for (int i = 0; i < 40; i++) begin
            c = cycle;
            tick();
            if (s_req_fire && first_req < 0) first_req = c;
            if (s_valid_next && first_vn < 0) first_vn = c;
        end
        checks++;
        if (first_req < 0 || first_vn != first_req + 2) begin
            errors++; $display("FAIL first_latency: got valid at %0d expected %0d", first_vn, first_req + 2);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_log.size() <= i || req_log[i] !== RESET_PC + 32'(4 * i)) begin
                errors++; $display("FAIL stream_addr %0d: got %h expected %h", i,
                                   req_log.size() > i ? req_log[i] : 32'hx, RESET_PC + 32'(4 * i));
            end
        end
        checks++;
        if (delivered.size() < 8) begin
            errors++; $display("FAIL stream_count: got %0d expected at least 8", delivered.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (delivered[i].pc !== RESET_PC + 32'(4 * i) || delivered[i].inst !== data_of(RESET_PC + 32'(4 * i))) begin
                    errors++; $display("FAIL stream_pair %0d: got %h/%h expected %h/%h", i, delivered[i].pc,
                                       delivered[i].inst, RESET_PC + 32'(4 * i), data_of(RESET_PC + 32'(4 * i)));
                end
            end
        end
    endtask

    task automatic test_decode_stall();
        int n0;
        do_reset();
        ready_next = 1'b1;
        repeat (5) tick();
        ready_next = 1'b0;
        repeat (6) tick();
        checks++;
        if (s_req_valid !== 1'b0 || s_valid_next !== 1'b1) begin
            errors++; $display("FAIL stall_full: got req=%b vn=%b expected 0/1", s_req_valid, s_valid_next);
        end
        n0 = delivered.size();
        ready_next = 1'b1;
        tick();
        tick();
        checks++;
        if (delivered.size() - n0 != DEPTH) begin
            errors++; $display("FAIL stall_drain: got %0d expected %0d", delivered.size() - n0, DEPTH);
        end
        tick();
        checks++;
        if (s_valid_next !== 1'b0) begin
            errors++; $display("FAIL stall_empty: got %b expected 0", s_valid_next);
        end
        repeat (10) tick();
        for (int i = 0; i < delivered.size(); i++) begin
            checks++;
            if (delivered[i].pc !== RESET_PC + 32'(4 * i) || delivered[i].inst !== data_of(delivered[i].pc)) begin
                errors++; $display("FAIL stall_order %0d: got %h/%h expected pc %h", i,
                                   delivered[i].pc, delivered[i].inst, RESET_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_mem_stall();
        do_reset();
        ready_next = 1'b1;
        mem_ready_mode = 0;
        repeat (3) begin
            tick();
            checks++;
            if (s_req_valid !== 1'b1 || s_addr !== RESET_PC) begin
                errors++; $display("FAIL mem_hold: got req=%b addr=%h expected 1/%h", s_req_valid, s_addr, RESET_PC);
            end
        end
        mem_ready_mode = 1;
        tick();
        checks++;
        if (req_log.size() != 1 || req_log[0] !== RESET_PC) begin
            errors++; $display("FAIL mem_release: got %0d requests expected 1 at %h", req_log.size(), RESET_PC);
        end
        tick();
        checks++;
        if (s_addr !== RESET_PC + 32'd4) begin
            errors++; $display("FAIL mem_advance: got %h expected %h", s_addr, RESET_PC + 32'd4);
        end
        repeat (6) tick();
    endtask

    task automatic test_redirect();
        do_reset();
        ready_next = 1'b0;
        tick();
        lat_min = 6; lat_max = 6;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0103;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (s_valid_next !== 1'b0 || s_req_valid !== 1'b0) begin
            errors++; $display("FAIL redirect_cycle: got vn=%b req=%b expected 0/0", s_valid_next, s_req_valid);
        end
        lat_min = 1; lat_max = 1;
        ready_next = 1'b1;
        tick();
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== 32'h8000_0100) begin
            errors++; $display("FAIL redirect_target: got req=%b addr=%h expected 1/80000100", s_req_valid, s_addr);
        end
        repeat (15) tick();
        checks++;
        if (delivered.size() == 0) begin
            errors++; $display("FAIL redirect_deliver: got 0 pairs expected at least 1");
        end
        for (int i = 0; i < delivered.size(); i++) begin
            checks++;
            if (delivered[i].pc !== 32'h8000_0100 + 32'(4 * i) || delivered[i].inst !== data_of(delivered[i].pc)) begin
                errors++; $display("FAIL redirect_pair %0d: got %h/%h expected pc %h", i,
                                   delivered[i].pc, delivered[i].inst, 32'h8000_0100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_back_to_back_redirect();
        int  n0, waited = 0;
        logic found = 1'b0;
        do_reset();
        lat_min = 1; lat_max = 2;
        ready_next = 1'b1;
        repeat (6) tick();
        while (!found && waited < 20) begin
            if (m_flight.size() > 0 && m_flight[0].due <= cycle) found = 1'b1;
            else begin tick(); waited++; end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL b2b_setup: got no response within 20 cycles expected one");
        end
        n0 = delivered.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0040;
        tick();
        redirect_pc = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        repeat (15) tick();
        checks++;
        if (delivered.size() <= n0) begin
            errors++; $display("FAIL b2b_deliver: got 0 pairs expected at least 1");
        end
        for (int i = n0; i < delivered.size(); i++) begin
            checks++;
            if (delivered[i].pc !== 32'h8000_0200 + 32'(4 * (i - n0)) || delivered[i].inst !== data_of(delivered[i].pc)) begin
                errors++; $display("FAIL b2b_pair %0d: got %h/%h expected pc %h", i - n0,
                                   delivered[i].pc, delivered[i].inst, 32'h8000_0200 + 32'(4 * (i - n0)));
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        mem_ready_mode = 2;
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            ready_next     = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(15) == 0);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        checks++;
        if (delivered.size() < 100) begin
            errors++; $display("FAIL random_progress: got %0d pairs expected at least 100", delivered.size());
        end
        foreach (delivered[i]) if (delivered[i].inst !== data_of(delivered[i].pc) || delivered[i].pc[1:0] != 2'b00) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL random_pairs: got %0d inconsistent pairs expected 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        int n0;
        do_reset();
        ready_next = 1'b1;
        repeat (7) tick();
        rst = 1'b1;
        ready_next = 1'b0;
        tick();
        checks++;
        if (s_req_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_req: got %b expected 0", s_req_valid);
        end
        rst = 1'b0;
        ready_next = 1'b1;
        n0 = delivered.size();
        tick();
        checks++;
        if (s_valid_next !== 1'b0 || s_pc !== 32'h0 || s_inst !== 32'h0) begin
            errors++; $display("FAIL midrst_outputs: got vn=%b pc=%h inst=%h expected 0/0/0", s_valid_next, s_pc, s_inst);
        end
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== RESET_PC) begin
            errors++; $display("FAIL midrst_restart: got req=%b addr=%h expected 1/%h", s_req_valid, s_addr, RESET_PC);
        end
        repeat (10) tick();
        checks++;
        if (delivered.size() <= n0 || delivered[n0].pc !== RESET_PC) begin
            errors++; $display("FAIL midrst_first: got %h expected %h",
                               delivered.size() > n0 ? delivered[n0].pc : 32'hx, RESET_PC);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_decode_stall();
        test_mem_stall();
        test_redirect();
        test_back_to_back_redirect();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
